// File: rtl/hp0_arb_pkg.sv
// Shared types and constants for the HP0 write-port arbiter.
// burst_legal() rejects misaligned starts and bursts that would cross a 4 KB page.
package hp0_arb_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam int         BOUNDARY_4K    = 4096;
  localparam int         N_REQ          = 2;

  // A burst may end exactly on the page boundary, hence <=.
  function automatic logic burst_legal(input logic [11:0] offs, input logic [3:0] len);
    logic [13:0] end_b;
    end_b = {2'b00, offs} + ({10'd0, len} + 14'd1) * 14'd8;
    return (offs[2:0] == 3'b000) && (end_b <= 14'(BOUNDARY_4K));
  endfunction

endpackage

// File: rtl/hp0_rr_arb.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module hp0_rr_arb
  import hp0_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    grant     = 2'b00;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    if (req_valid != 2'b00)
      grant = 2'b01 << grant_idx;
  end

endmodule

// File: rtl/hp0_write_arbiter.sv
// Shares the HP0 AXI3 write port between two burst requesters, one burst at a
// time, holding the grant from AW issue through the B response.
//
// state | meaning
// IDLE  | no owner; arbitrate (skipped while a ready/done pulse is out)
// AW    | address presented, waiting for awready
// W     | data beats muxed from the owner, wlast on beat awlen
// B     | bready high, waiting for the write response
module hp0_write_arbiter
  import hp0_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int N_REQ      = 2
) (
  input  logic                    aclk,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*4-1:0]      req_len_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [N_REQ-1:0]        req_wvalid_i,
  output logic [N_REQ-1:0]        req_wready_o,
  output logic [N_REQ-1:0]        req_done_o,
  output logic [1:0]              req_bresp_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o,
  output logic                    error_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp
);

  state_t                state;
  logic                  last_grant;
  logic                  g_idx;
  logic [3:0]            beat_cnt;
  logic [1:0]            pick;
  logic                  pick_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [3:0]            sel_len;
  logic                  sel_legal;
  logic                  settle;

  hp0_rr_arb u_rr (
    .req_valid (req_valid_i),
    .last_grant(last_grant),
    .grant     (pick),
    .grant_idx (pick_idx)
  );

  assign sel_addr  = pick_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign sel_len   = pick_idx ? req_len_i[7:4] : req_len_i[3:0];
  assign sel_legal = burst_legal(sel_addr[11:0], sel_len);
  // Requesters still show the old descriptor while ready/done is pulsing.
  assign settle    = (req_ready_o != '0) || (req_done_o != '0);

  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state == W) && (beat_cnt == m_axi_awlen);

  always_comb begin
    m_axi_wdata  = '0;
    m_axi_wvalid = 1'b0;
    req_wready_o = '0;
    if (state == W) begin
      m_axi_wdata          = g_idx ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
      m_axi_wvalid         = req_wvalid_i[g_idx];
      req_wready_o[g_idx]  = m_axi_wready;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      g_idx         <= 1'b0;
      beat_cnt      <= '0;
      req_ready_o   <= '0;
      req_done_o    <= '0;
      req_bresp_o   <= '0;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      error_o       <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      req_ready_o <= '0;
      req_done_o  <= '0;
      case (state)
        IDLE: begin
          if ((pick != 2'b00) && !settle) begin
            req_ready_o <= pick;
            if (sel_legal) begin
              grant_o       <= pick;
              g_idx         <= pick_idx;
              m_axi_awaddr  <= sel_addr;
              m_axi_awlen   <= sel_len;
              m_axi_awvalid <= 1'b1;
              busy_o        <= 1'b1;
              state         <= AW;
            end else begin
              req_done_o  <= pick;
              req_bresp_o <= RESP_SLVERR;
              error_o     <= 1'b1;
              last_grant  <= pick_idx;
            end
          end
        end
        AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= W;
          end
        end
        W: begin
          if (m_axi_wvalid && m_axi_wready) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (m_axi_wlast) begin
              m_axi_bready <= 1'b1;
              state        <= B;
            end
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            m_axi_bready      <= 1'b0;
            req_done_o[g_idx] <= 1'b1;
            req_bresp_o       <= m_axi_bresp;
            error_o           <= error_o | (m_axi_bresp != RESP_OKAY);
            last_grant        <= g_idx;
            grant_o           <= '0;
            busy_o            <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hp0_write_arbiter.sv
// Directed bench for hp0_write_arbiter: a table of single bursts plus hand
// sequences for arbitration order, throttled data, error response and reset.
module tb_hp0_write_arbiter;

  logic         aclk = 1'b0;
  logic         rst_i = 1'b1;
  logic [1:0]   req_valid_i = '0;
  logic [63:0]  req_addr_i = '0;
  logic [7:0]   req_len_i = '0;
  logic [1:0]   req_ready_o;
  logic [127:0] req_wdata_i = '0;
  logic [1:0]   req_wvalid_i = '0;
  logic [1:0]   req_wready_o;
  logic [1:0]   req_done_o;
  logic [1:0]   req_bresp_o;
  logic [1:0]   grant_o;
  logic         busy_o;
  logic         error_o;
  logic [31:0]  m_axi_awaddr;
  logic [3:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1'b0;
  logic [63:0]  m_axi_wdata;
  logic [7:0]   m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;
  logic [1:0]   m_axi_bresp = 2'b00;

  hp0_write_arbiter dut (
    .aclk(aclk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o), .req_wdata_i(req_wdata_i), .req_wvalid_i(req_wvalid_i),
    .req_wready_o(req_wready_o), .req_done_o(req_done_o), .req_bresp_o(req_bresp_o),
    .grant_o(grant_o), .busy_o(busy_o), .error_o(error_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // slave / requester model state
  int          aw_lat = 0;
  bit          wr_toggle = 0;
  bit          gap = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  int          aw_wait = 0;
  bit          aw_open = 0;
  bit          b_pend = 0;
  int          b_cd = 0;
  int          beats = 0;
  int          aw_cnt = 0;
  int          tick = 0;
  int          w_total[2] = '{0, 0};
  int          w_sent[2] = '{0, 0};
  int          exp_owner = 0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_len = '0;

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [3:0]  len;
    bit          legal;
    int          lat;
    bit          err;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int r, input int i);
    return {32'(r + 1), 32'h5A5A_0000 | 32'(i)};
  endfunction

  // Drive slave and requester data at the falling edge, then sample the
  // handshakes that the next rising edge will complete.
  always @(negedge aclk) begin
    tick++;
    if (rst_i) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      aw_wait = 0; aw_open = 0; b_pend = 0; b_cd = 0;
      req_wvalid_i = '0;
    end else begin
      m_axi_awready = m_axi_awvalid && (aw_wait >= aw_lat);
      if (m_axi_awvalid && !m_axi_awready) aw_wait++;
      m_axi_wready = wr_toggle ? ~m_axi_wready : 1'b1;
      if (b_pend && b_cd > 0) b_cd--;
      m_axi_bvalid = b_pend && (b_cd == 0);
      m_axi_bresp  = cfg_bresp;
      for (int r = 0; r < 2; r++) begin
        req_wdata_i[r*64 +: 64] = mk(r, w_sent[r]);
        req_wvalid_i[r] = (w_sent[r] < w_total[r]) && (!gap || (tick % 3 != 2));
      end
      #1;
      if (m_axi_awvalid) begin
        chk("aw_addr", m_axi_awaddr, exp_addr);
        chk("aw_len", m_axi_awlen, exp_len);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_overlap", {aw_open, b_pend}, 0);
        aw_open = 1; beats = 0; aw_wait = 0; aw_cnt++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_after_aw", aw_open, 1);
        chk("w_data", m_axi_wdata, mk(exp_owner, beats));
        chk("w_last", m_axi_wlast, beats == int'(exp_len));
        chk("w_other_ready", req_wready_o[1-exp_owner], 0);
        beats++;
        if (m_axi_wlast) begin aw_open = 0; b_pend = 1; b_cd = 2; end
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      for (int r = 0; r < 2; r++)
        if (req_wvalid_i[r] && req_wready_o[r]) w_sent[r]++;
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_desc(input int r, input logic [31:0] a, input logic [3:0] l);
    req_addr_i[r*32 +: 32] = a;
    req_len_i[r*4 +: 4] = l;
    req_valid_i[r] = 1'b1;
  endtask

  task automatic wait_ready(input logic [1:0] exp_mask, input string name);
    int n = 0;
    do begin cyc(); n++; end while (req_ready_o == 2'b00 && n < 40);
    chk(name, req_ready_o, exp_mask);
  endtask

  task automatic start_stream(input int r, input logic [31:0] a, input logic [3:0] l);
    exp_owner = r; exp_addr = a; exp_len = l;
    w_sent[r] = 0; w_total[r] = int'(l) + 1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_done(input int r, input logic [1:0] br, input string name);
    int n = 0;
    do begin cyc(); n++; end while (req_done_o[r] == 1'b0 && n < 300);
    chk({name, "_done"}, req_done_o, 2'b01 << r);
    chk({name, "_bresp"}, req_bresp_o, br);
    chk({name, "_beats"}, beats, int'(exp_len) + 1);
    chk({name, "_idle"}, {grant_o, busy_o}, 0);
    w_total[r] = 0;
    cyc();
    chk({name, "_pulse"}, req_done_o, 0);
  endtask

  task automatic do_burst(input int r, input logic [31:0] a, input logic [3:0] l,
                          input bit legal, input bit err, input string name);
    int aw0 = aw_cnt;
    set_desc(r, a, l);
    wait_ready(2'b01 << r, {name, "_ready"});
    if (legal) begin
      chk({name, "_grant"}, {grant_o, busy_o, req_done_o}, {2'b01 << r, 1'b1, 2'b00});
      start_stream(r, a, l);
      wait_done(r, cfg_bresp, name);
      chk({name, "_aw_count"}, aw_cnt - aw0, 1);
    end else begin
      chk({name, "_rej"}, {req_done_o, req_bresp_o, m_axi_awvalid, grant_o}, {2'b01 << r, 2'b10, 1'b0, 2'b00});
      req_valid_i[r] = 1'b0;
      cyc();
      chk({name, "_rej_quiet"}, {m_axi_awvalid, busy_o, req_done_o}, 0);
      chk({name, "_aw_count"}, aw_cnt - aw0, 0);
    end
    chk({name, "_error"}, error_o, err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 32'h1000_0000, 4'd15, 1'b1, 0, 1'b0};
    tbl[1] = '{1, 32'h1000_0F80, 4'd15, 1'b1, 2, 1'b0};
    tbl[2] = '{1, 32'h1000_0F88, 4'd15, 1'b0, 0, 1'b1};
    tbl[3] = '{0, 32'h1000_0004, 4'd0,  1'b0, 0, 1'b1};
    tbl[4] = '{0, 32'h1000_0040, 4'd3,  1'b1, 1, 1'b1};
    tbl[5] = '{1, 32'h1000_0FF8, 4'd0,  1'b1, 0, 1'b1};
    tbl[6] = '{0, 32'h1000_0FF8, 4'd1,  1'b0, 0, 1'b1};

    rst_i = 1'b1;
    repeat (3) cyc();
    chk("reset_regs", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen, req_ready_o, req_done_o,
                       req_bresp_o, grant_o, busy_o, error_o, m_axi_bready}, 0);
    chk("reset_w", {m_axi_wvalid, m_axi_wlast, req_wready_o}, 0);
    chk("consts", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'b011, 2'b01, 8'hFF});
    rst_i = 1'b0;
    cyc();

    // both requesters valid from reset: r0, r1, then r0 again
    set_desc(0, 32'h1000_1000, 4'd3);
    set_desc(1, 32'h1000_1100, 4'd3);
    wait_ready(2'b01, "tie_first_r0");
    start_stream(0, 32'h1000_1000, 4'd3);
    wait_done(0, 2'b00, "alt_r0a");
    wait_ready(2'b10, "alt_then_r1");
    start_stream(1, 32'h1000_1100, 4'd3);
    set_desc(0, 32'h1000_1200, 4'd3);
    wait_done(1, 2'b00, "alt_r1a");
    set_desc(1, 32'h1000_1300, 4'd3);
    wait_ready(2'b01, "alt_back_r0");
    start_stream(0, 32'h1000_1200, 4'd3);
    wait_done(0, 2'b00, "alt_r0b");
    wait_ready(2'b10, "alt_back_r1");
    start_stream(1, 32'h1000_1300, 4'd3);
    wait_done(1, 2'b00, "alt_r1b");
    chk("alt_error", error_o, 0);

    for (int i = 0; i < 7; i++) begin
      aw_lat = tbl[i].lat;
      do_burst(tbl[i].r, tbl[i].addr, tbl[i].len, tbl[i].legal, tbl[i].err, $sformatf("v%0d", i));
      aw_lat = 0;
      cyc();
    end

    // throttled wready and gapped wvalid, r1 streaming but never granted
    wr_toggle = 1; gap = 1;
    w_sent[1] = 0; w_total[1] = 8;
    do_burst(0, 32'h1000_3000, 4'd7, 1'b1, 1'b1, "throttle");
    chk("throttle_r1_no_beats", w_sent[1], 0);
    wr_toggle = 0; gap = 0; w_total[1] = 0;
    cyc();

    // reset during W after three accepted beats
    begin
      int n = 0;
      set_desc(0, 32'h1000_2000, 4'd7);
      wait_ready(2'b01, "rst_ready");
      start_stream(0, 32'h1000_2000, 4'd7);
      while (beats < 3 && n < 100) begin cyc(); n++; end
      chk("rst_reached_beat3", beats == 3 && m_axi_wvalid == 1'b0 ? 1 : beats >= 3, 1);
      rst_i = 1'b1;
      cyc();
      chk("rst_mid_outputs", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen, req_ready_o, req_done_o,
                              req_bresp_o, grant_o, busy_o, m_axi_bready, m_axi_wvalid, m_axi_wlast}, 0);
      chk("rst_mid_error_clear", error_o, 0);
      w_total[0] = 0;
      rst_i = 1'b0;
      cyc();
    end

    // after reset r0 wins the tie again
    set_desc(0, 32'h1000_4000, 4'd0);
    set_desc(1, 32'h1000_4100, 4'd0);
    wait_ready(2'b01, "post_rst_tie_r0");
    start_stream(0, 32'h1000_4000, 4'd0);
    wait_done(0, 2'b00, "post_rst_r0");
    wait_ready(2'b10, "post_rst_r1");
    start_stream(1, 32'h1000_4100, 4'd0);
    wait_done(1, 2'b00, "post_rst_r1");
    chk("post_rst_error", error_o, 0);

    // SLVERR on a legal burst sets the sticky error
    cfg_bresp = 2'b10;
    do_burst(1, 32'h1000_5000, 4'd2, 1'b1, 1'b1, "slverr");
    cfg_bresp = 2'b00;
    do_burst(0, 32'h1000_6000, 4'd1, 1'b1, 1'b1, "after_slverr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp0_write_arbiter.md
Name: hp0_write_arbiter

Overview:
Shares the single HP0 AXI3 write port (64-bit data, 4-bit awlen) between two burst requesters: the capture-DMA path and a secondary logger/snapshot source.
- Each requester presents a complete burst descriptor (address, length) and then streams its data beats.
- The arbiter grants one burst at a time, round-robin, and holds the grant from AW issue through the B response.
- It rejects illegal bursts locally and returns a per-requester done pulse with the response code.
- It sits between the requesters and the HP0 wrapper ports, all in the fclk0 domain.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI write data width; strobe width is DATA_WIDTH/8
N_REQ, 2, number of requesters; fixed at 2 for this revision

Ports:
aclk  input  1  HP0 clock (fclk0)
rst_i  input  1  synchronous active-high reset
req_valid_i  input  2  per-requester burst descriptor valid
req_addr_i  input  2*ADDR_WIDTH  per-requester start byte address; slice [i*32 +: 32]
req_len_i  input  2*4  per-requester beats-1 (0..15)
req_ready_o  output  2  one-cycle pulse: descriptor accepted
req_wdata_i  input  2*DATA_WIDTH  per-requester write data
req_wvalid_i  input  2  per-requester data valid
req_wready_o  output  2  per-requester data accept
req_done_o  output  2  one-cycle pulse: burst complete or rejected
req_bresp_o  output  2  response code of the last completed burst; common to both requesters, qualify with req_done_o
grant_o  output  2  one-hot current owner; 0 when idle
busy_o  output  1  state != IDLE
error_o  output  1  sticky: any nonzero bresp or any rejection; cleared only by rst_i
m_axi_awaddr  output  ADDR_WIDTH  write address
m_axi_awlen  output  4  burst length
m_axi_awsize  output  3  constant 3'b011 (8 bytes)
m_axi_awburst  output  2  constant 2'b01 (INCR)
m_axi_awvalid  output  1  address valid
m_axi_awready  input  1  address ready
m_axi_wdata  output  DATA_WIDTH  write data
m_axi_wstrb  output  DATA_WIDTH/8  constant all ones
m_axi_wlast  output  1  last beat
m_axi_wvalid  output  1  data valid
m_axi_wready  input  1  data ready
m_axi_bvalid  input  1  response valid
m_axi_bready  output  1  response ready
m_axi_bresp  input  2  response code

Behaviour:
- Reset values:
  - Registered outputs are 0: awvalid, awaddr, awlen, req_ready_o, req_done_o, req_bresp_o, grant_o, busy_o, error_o, bready.
  - State is IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
- State machine: IDLE -> AW -> W -> B -> IDLE, plus a REJECT path IDLE -> IDLE.
- IDLE, at cycle N:
  - Select a requester: if exactly one req_valid_i is set, take it; if both are set, take !last_grant.
  - Legality check: addr[2:0]==0, and (addr[11:0] + (len+1)*8) <= 4096. A burst may end exactly on a 4 KB boundary.
  - Legal burst: at N+1, req_ready_o[g] pulses, grant_o = 1<<g, awaddr/awlen are latched, awvalid=1, state=AW.
  - Illegal burst: at N+1, req_ready_o[g] and req_done_o[g] pulse together, req_bresp_o=2'b10, error_o=1. last_grant := g. No AXI traffic. Stay IDLE, with no new selection in that cycle.
- AW:
  - Hold awvalid, awaddr and awlen stable until awready.
  - On the handshake: awvalid=0 next cycle, beat counter := 0, state=W.
- W (combinational mux from the granted requester g):
  - m_axi_wdata = req_wdata[g]; m_axi_wvalid = req_wvalid[g].
  - req_wready_o[g] = m_axi_wready; the non-granted requester sees wready=0.
  - m_axi_wlast = (count == awlen) while in W.
  - Each wvalid&wready beat increments count.
  - The last-beat handshake moves to B.
  - Data is never issued before the AW handshake.
- B:
  - bready=1.
  - On bvalid: req_done_o[g] pulses the next cycle, req_bresp_o := bresp, error_o |= (bresp != 0), last_grant := g, grant_o=0, state=IDLE.
  - The next arbitration starts the cycle after the return to IDLE, giving a minimum 1-cycle bubble between bursts.
- A requester must hold its descriptor until req_ready_o. A deasserted req_valid_i before grant withdraws it.
- W outputs are 0 outside W; bready is 0 outside B.
- rst_i asserted mid-burst: all state and outputs return to reset values the next cycle. The system must reset the HP0 interconnect alongside, because partial bursts are abandoned.

Decomposition:
- Package hp0_arb_pkg holds:
  - state_t enum {IDLE, AW, W, B}
  - AXI_SIZE_8B = 3'b011, AXI_BURST_INCR = 2'b01
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - BOUNDARY_4K = 4096, N_REQ = 2
- One sub-module: hp0_rr_arb, a 2-way round-robin pick from req_valid and last_grant, returning a one-hot grant and an index.

Test Plan:
- r0 only, addr 0x1000_0000, len 15, wready always 1, bvalid 2 cycles after wlast with OKAY -> awaddr 0x1000_0000, awlen 15, 16 beats, wlast on beat 16, req_done_o[0] pulses once, req_bresp_o=00, error_o=0.
- r0 and r1 both valid from reset, len 3 each -> r0 granted first, then r1. Both then hold valid again -> r0 next (alternation). No AW overlap between bursts.
- r1 addr 0x1000_0F80, len 15 (ends exactly on 4 KB) -> legal, issued. r1 addr 0x1000_0F88, len 15 -> rejected: req_ready_o and req_done_o pulse together, bresp=10, error_o=1, no awvalid.
- r0 addr 0x1000_0004 (misaligned) -> rejected as above. Then r0 legal burst -> proceeds normally; error_o stays 1.
- wready toggled 1-0-1-0 and req_wvalid gapped, len 7 -> exactly 8 beats with data in order, wlast only on the 8th accepted beat, no beats granted to r1.
- bresp=10 on a legal burst -> error_o=1. rst_i asserted during W at beat 3 -> next cycle all outputs 0, grant_o=0, error_o=0, and r0 wins the next tie.
